// File: rtl/axi_ram_rr_port_arb.sv
// Round-robin arbiter that shares one AXI4 slave between two single-word requesters.
// Only one single-beat transaction is in flight at a time, and its response is routed back to the requester that owns it.
module axi_ram_rr_port_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    RESET,

  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  input  logic [2*STRB_WIDTH-1:0] req_wstrb,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,

  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [STRB_WIDTH-1:0]   m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t                  state;
  logic                    last_grant;
  logic                    owner;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;

  logic                    grant;
  logic                    grant_any;

  // With only one transaction outstanding, response IDs and rlast carry no extra information.
  logic unused_ok;
  assign unused_ok = ^{m_axi_bid, m_axi_rid, m_axi_rlast};

  // Give priority to the port that was not granted last, and fall back to the other port if it is idle.
  // NOTE: every always_comb output gets a default first so that no path leaves it unassigned (no latch).
  always_comb begin
    grant     = last_grant;
    grant_any = 1'b0;
    if (state == IDLE && !RESET) begin
      if (req_valid[~last_grant]) begin
        grant     = ~last_grant;
        grant_any = 1'b1;
      end else if (req_valid[last_grant]) begin
        grant     = last_grant;
        grant_any = 1'b1;
      end
    end
  end

  assign req_ready = grant_any ? (grant ? 2'b10 : 2'b01) : 2'b00;

  assign m_axi_awid    = ID_WIDTH'(owner);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'($clog2(STRB_WIDTH));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_arid    = ID_WIDTH'(owner);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'($clog2(STRB_WIDTH));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;

  // NOTE: all sequential state uses non-blocking assignments, so every register samples its pre-edge value.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 2'b00;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
    end else begin
      rsp_valid <= 2'b00;
      case (state)
        IDLE: begin
          if (grant_any) begin
            last_grant <= grant;
            owner      <= grant;
            addr_q     <= grant ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
            wdata_q    <= grant ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
            wstrb_q    <= grant ? req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : req_wstrb[STRB_WIDTH-1:0];
            if (req_we[grant]) begin
              state         <= WR_ADDR_DATA;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
            end else begin
              state         <= RD_ADDR;
              m_axi_arvalid <= 1'b1;
            end
          end
        end
        // AW and W complete independently; each valid falls after its own handshake and is never raised again.
        WR_ADDR_DATA: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            state        <= WR_RESP;
            m_axi_bready <= 1'b1;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            rsp_rdata    <= '0;
            rsp_resp     <= m_axi_bresp;
            rsp_valid    <= owner ? 2'b10 : 2'b01;
            m_axi_bready <= 1'b0;
            state        <= IDLE;
          end
        end
        RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_valid    <= owner ? 2'b10 : 2'b01;
            m_axi_rready <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_rr_port_arb.sv
// Bench for axi_ram_rr_port_arb: a small zero-wait AXI RAM model, a byte-level reference memory,
// and a round-robin grant model. Responses are checked in the order the requests were granted.
`timescale 1ns/1ps
module tb_axi_ram_rr_port_arb;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;
  localparam int IW = 8;

  logic clk = 1'b0;
  logic RESET;
  always #5 clk = ~clk;

  logic [1:0] req_valid, req_ready, req_we, rsp_valid, rsp_resp;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*SW-1:0] req_wstrb;
  logic [DW-1:0] rsp_rdata;
  logic [IW-1:0] m_axi_awid, m_axi_bid, m_axi_arid, m_axi_rid;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0] m_axi_awlen, m_axi_arlen;
  logic [2:0] m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0] m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic [3:0] m_axi_awcache, m_axi_arcache;
  logic m_axi_awlock, m_axi_arlock, m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [SW-1:0] m_axi_wstrb;

  axi_ram_rr_port_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) dut (
    .clk(clk), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // ---------------- AXI RAM slave model (word array, cleared on reset) ----------------
  logic [31:0] ram [0:255];
  logic aw_got, w_got, ar_pend, b_hold;
  logic [AW-1:0] aw_addr_q, ar_addr_q;
  logic [31:0] w_data_q;
  logic [3:0] w_strb_q;
  logic [1:0] slave_resp;

  wire aw_hit = m_axi_awvalid && m_axi_awready;
  wire w_hit  = m_axi_wvalid && m_axi_wready;
  wire have_aw = aw_got || aw_hit;
  wire have_w  = w_got || w_hit;
  wire [AW-1:0] wr_addr = aw_hit ? m_axi_awaddr : aw_addr_q;
  wire [31:0] wr_data = w_hit ? m_axi_wdata : w_data_q;
  wire [3:0] wr_strb = w_hit ? m_axi_wstrb : w_strb_q;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (RESET) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_pend <= 1'b0;
      aw_addr_q <= '0; ar_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0;
      m_axi_bvalid <= 1'b0; m_axi_bid <= '0; m_axi_bresp <= 2'b00;
      m_axi_rvalid <= 1'b0; m_axi_rid <= '0; m_axi_rdata <= '0; m_axi_rresp <= 2'b00; m_axi_rlast <= 1'b0;
    end else begin
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (have_aw && have_w && !b_hold && !m_axi_bvalid) begin
        ram[wr_addr[9:2]] <= merge(ram[wr_addr[9:2]], wr_data, wr_strb);
        m_axi_bvalid <= 1'b1;
        m_axi_bresp <= slave_resp;
        aw_got <= 1'b0;
        w_got <= 1'b0;
      end else begin
        if (aw_hit) begin aw_got <= 1'b1; aw_addr_q <= m_axi_awaddr; end
        if (w_hit) begin w_got <= 1'b1; w_data_q <= m_axi_wdata; w_strb_q <= m_axi_wstrb; end
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin ar_pend <= 1'b1; ar_addr_q <= m_axi_araddr; end
      if (ar_pend) begin
        ar_pend <= 1'b0;
        m_axi_rvalid <= 1'b1;
        m_axi_rdata <= ram[ar_addr_q[9:2]];
        m_axi_rresp <= slave_resp;
        m_axi_rlast <= 1'b1;
      end
    end
  end

  // ---------------- Monitor: logs grants, responses and handshakes at negedge ----------------
  int cyc = 0;
  logic [1:0] grant_q[$], rsp_own_q[$], rsp_resp_q[$];
  int grant_cyc_q[$], rsp_cyc_q[$];
  logic [31:0] rsp_data_q[$];
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, awv_cycles = 0, wv_cycles = 0;
  logic [IW-1:0] last_awid, last_arid;
  logic [AW-1:0] last_awaddr, last_araddr;
  logic [7:0] last_awlen, last_arlen;
  logic last_wlast;
  logic [31:0] last_wdata;
  logic [3:0] last_wstrb;

  always @(negedge clk) begin
    cyc++;
    if (req_ready != 2'b00) begin grant_q.push_back(req_ready); grant_cyc_q.push_back(cyc); end
    if (rsp_valid != 2'b00) begin
      rsp_own_q.push_back(rsp_valid); rsp_data_q.push_back(rsp_rdata);
      rsp_resp_q.push_back(rsp_resp); rsp_cyc_q.push_back(cyc);
    end
    if (m_axi_awvalid) awv_cycles++;
    if (m_axi_wvalid) wv_cycles++;
    if (m_axi_awvalid && m_axi_awready) begin
      aw_hs++; last_awid = m_axi_awid; last_awaddr = m_axi_awaddr; last_awlen = m_axi_awlen;
    end
    if (m_axi_wvalid && m_axi_wready) begin
      w_hs++; last_wlast = m_axi_wlast; last_wdata = m_axi_wdata; last_wstrb = m_axi_wstrb;
    end
    if (m_axi_bvalid && m_axi_bready) b_hs++;
    if (m_axi_arvalid && m_axi_arready) begin
      ar_hs++; last_arid = m_axi_arid; last_araddr = m_axi_araddr; last_arlen = m_axi_arlen;
    end
  end

  // ---------------- Reference model: byte memory + round-robin rule ----------------
  logic [7:0] ref_mem [0:1023];
  int ref_last = 1;
  int errors = 0;
  int checks = 0;

  function automatic int ref_pick(input logic [1:0] v);
    int other, g;
    other = 1 - ref_last;
    g = -1;
    if (v[other]) g = other;
    else if (v[ref_last]) g = ref_last;
    if (g >= 0) ref_last = g;
    return g;
  endfunction

  function automatic logic [31:0] ref_read(input logic [AW-1:0] a);
    int base;
    base = int'(a) & 32'h3FC;
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  task automatic ref_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int base;
    base = int'(a) & 32'h3FC;
    for (int b = 0; b < 4; b++) if (s[b]) ref_mem[base+b] = d[8*b +: 8];
  endtask

  function automatic logic [1:0] oh(input int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic wait_neg();
    @(negedge clk); #1;
  endtask

  task automatic set_port(input int port, input bit we, input logic [AW-1:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
    req_we[port] = we;
    req_addr[port*AW +: AW] = addr;
    req_wdata[port*DW +: DW] = data;
    req_wstrb[port*SW +: SW] = strb;
  endtask

  // One request from a lone port; checks grant, AXI fields, response and latency.
  task automatic run_txn(input int port, input bit we, input logic [AW-1:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input bit chk_lat, input string name, output logic [31:0] got);
    int g0, r0, aw0, w0, ar0, b0, n, exp_g, lat;
    logic [31:0] exp_d;
    got = 32'h0;
    @(posedge clk); #1;
    g0 = grant_q.size(); r0 = rsp_own_q.size();
    aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs; b0 = b_hs;
    set_port(port, we, addr, data, strb);
    req_valid[port] = 1'b1;
    n = 0;
    while (grant_q.size() == g0 && n < 50) begin wait_neg(); n++; end
    exp_g = ref_pick(oh(port));
    checks++;
    if (grant_q.size() == g0) begin
      errors++; $display("FAIL %s grant timeout", name); req_valid[port] = 1'b0; return;
    end
    @(posedge clk); #1;
    req_valid[port] = 1'b0;
    exp_d = we ? 32'h0 : ref_read(addr);
    if (we) ref_write(addr, data, strb);
    n = 0;
    while (rsp_own_q.size() == r0 && n < 100) begin wait_neg(); n++; end
    checks++;
    if (rsp_own_q.size() == r0) begin errors++; $display("FAIL %s response timeout", name); return; end
    wait_neg(); wait_neg();
    got = rsp_data_q[r0];
    checks++; if (grant_q[g0] !== oh(exp_g)) begin errors++; $display("FAIL %s grant got=%b exp=%b", name, grant_q[g0], oh(exp_g)); end
    checks++; if (rsp_own_q.size() - r0 !== 1) begin errors++; $display("FAIL %s rsp count got=%0d exp=1", name, rsp_own_q.size() - r0); end
    checks++; if (rsp_own_q[r0] !== oh(port)) begin errors++; $display("FAIL %s rsp_valid got=%b exp=%b", name, rsp_own_q[r0], oh(port)); end
    checks++; if (got !== exp_d) begin errors++; $display("FAIL %s rdata got=%h exp=%h", name, got, exp_d); end
    checks++; if (rsp_resp_q[r0] !== slave_resp) begin errors++; $display("FAIL %s resp got=%b exp=%b", name, rsp_resp_q[r0], slave_resp); end
    if (chk_lat) begin
      lat = rsp_cyc_q[r0] - grant_cyc_q[g0];
      checks++; if (lat !== (we ? 3 : 4)) begin errors++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, we ? 3 : 4); end
    end
    if (we) begin
      checks++; if ({aw_hs - aw0, w_hs - w0, b_hs - b0, ar_hs - ar0} !== {32'd1, 32'd1, 32'd1, 32'd0}) begin
        errors++; $display("FAIL %s handshakes aw=%0d w=%0d b=%0d ar=%0d exp 1/1/1/0", name, aw_hs - aw0, w_hs - w0, b_hs - b0, ar_hs - ar0); end
      checks++; if ({last_awid, last_awaddr, last_awlen, last_wlast} !== {IW'(port), addr, 8'd0, 1'b1}) begin
        errors++; $display("FAIL %s aw fields got id=%h addr=%h len=%h wlast=%b", name, last_awid, last_awaddr, last_awlen, last_wlast); end
      checks++; if ({last_wdata, last_wstrb} !== {data, strb}) begin
        errors++; $display("FAIL %s w fields got data=%h strb=%h exp %h/%h", name, last_wdata, last_wstrb, data, strb); end
    end else begin
      checks++; if ({ar_hs - ar0, aw_hs - aw0} !== {32'd1, 32'd0}) begin
        errors++; $display("FAIL %s handshakes ar=%0d aw=%0d exp 1/0", name, ar_hs - ar0, aw_hs - aw0); end
      checks++; if ({last_arid, last_araddr, last_arlen} !== {IW'(port), addr, 8'd0}) begin
        errors++; $display("FAIL %s ar fields got id=%h addr=%h len=%h", name, last_arid, last_araddr, last_arlen); end
    end
  endtask

  // Hold req_valid on the given ports for n_txn grants; check order, ownership, data and back-to-back timing.
  task automatic run_held(input logic [1:0] ports, input int n_txn, input string name);
    int g0, r0, n, g, ng, nr;
    int exp_g[$];
    logic [31:0] exp_d[$];
    logic [AW-1:0] a;
    @(posedge clk); #1;
    g0 = grant_q.size(); r0 = rsp_own_q.size();
    for (int k = 0; k < n_txn; k++) begin
      g = ref_pick(ports);
      exp_g.push_back(g);
      a = req_addr[g*AW +: AW];
      if (req_we[g]) begin
        exp_d.push_back(32'h0);
        ref_write(a, req_wdata[g*DW +: DW], req_wstrb[g*SW +: SW]);
      end else begin
        exp_d.push_back(ref_read(a));
      end
    end
    req_valid = ports;
    n = 0;
    while (grant_q.size() - g0 < n_txn && n < 400) begin wait_neg(); n++; end
    @(posedge clk); #1;
    req_valid = 2'b00;
    n = 0;
    while (rsp_own_q.size() - r0 < n_txn && n < 100) begin wait_neg(); n++; end
    wait_neg(); wait_neg();
    ng = grant_q.size() - g0;
    nr = rsp_own_q.size() - r0;
    checks++; if (ng !== n_txn) begin errors++; $display("FAIL %s grant count got=%0d exp=%0d", name, ng, n_txn); end
    checks++; if (nr !== n_txn) begin errors++; $display("FAIL %s rsp count got=%0d exp=%0d", name, nr, n_txn); end
    for (int k = 0; k < n_txn && k < ng && k < nr; k++) begin
      checks++; if (grant_q[g0+k] !== oh(exp_g[k])) begin errors++; $display("FAIL %s grant[%0d] got=%b exp=%b", name, k, grant_q[g0+k], oh(exp_g[k])); end
      checks++; if (rsp_own_q[r0+k] !== oh(exp_g[k])) begin errors++; $display("FAIL %s rsp_valid[%0d] got=%b exp=%b", name, k, rsp_own_q[r0+k], oh(exp_g[k])); end
      checks++; if (rsp_data_q[r0+k] !== exp_d[k]) begin errors++; $display("FAIL %s rdata[%0d] got=%h exp=%h", name, k, rsp_data_q[r0+k], exp_d[k]); end
      if (k > 0) begin
        checks++; if (grant_cyc_q[g0+k] !== rsp_cyc_q[r0+k-1]) begin
          errors++; $display("FAIL %s b2b[%0d] grant cycle got=%0d exp=%0d", name, k, grant_cyc_q[g0+k], rsp_cyc_q[r0+k-1]); end
      end
    end
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    repeat (3) @(posedge clk);
    wait_neg();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset req_ready got=%b exp=00", req_ready); end
    @(posedge clk); #1;
    RESET = 1'b0; req_valid = 2'b00;
    wait_neg();
    checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
      errors++; $display("FAIL reset axi handshakes got=%b exp=00000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}); end
    checks++; if ({rsp_valid, rsp_rdata, rsp_resp, req_ready} !== 38'b0) begin
      errors++; $display("FAIL reset rsp got valid=%b data=%h resp=%b ready=%b exp all 0", rsp_valid, rsp_rdata, rsp_resp, req_ready); end
    checks++; if ({m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot} !== {3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}) begin
      errors++; $display("FAIL reset aw constants got size=%h burst=%b cache=%h", m_axi_awsize, m_axi_awburst, m_axi_awcache); end
    checks++; if ({m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot} !== {3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}) begin
      errors++; $display("FAIL reset ar constants got size=%h burst=%b cache=%h", m_axi_arsize, m_axi_arburst, m_axi_arcache); end
  endtask

  task automatic test_write_read();
    logic [31:0] got;
    run_txn(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b1, "p0_write", got);
    run_txn(1, 1'b0, 16'h0010, 32'h0, 4'h0, 1'b1, "p1_read", got);
    checks++; if (got !== 32'hDEADBEEF) begin errors++; $display("FAIL p1_read value got=%h exp=deadbeef", got); end
  endtask

  task automatic test_alternation();
    set_port(0, 1'b1, 16'h0040, 32'h5A5A0001, 4'hF);
    set_port(1, 1'b0, 16'h0040, 32'h0, 4'h0);
    run_held(2'b11, 4, "alternate");
  endtask

  task automatic test_back_to_back();
    set_port(1, 1'b0, 16'h0010, 32'h0, 4'h0);
    run_held(2'b10, 3, "lone_b2b");
  endtask

  task automatic test_aw_stall();
    int g0, r0, aw0, w0, b0, awv0, wv0, n;
    logic [31:0] got;
    @(posedge clk); #1;
    g0 = grant_q.size(); r0 = rsp_own_q.size();
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; awv0 = awv_cycles; wv0 = wv_cycles;
    m_axi_awready = 1'b0;
    set_port(0, 1'b1, 16'h0080, 32'hC0FFEE11, 4'hF);
    req_valid[0] = 1'b1;
    n = 0;
    while (grant_q.size() == g0 && n < 50) begin wait_neg(); n++; end
    void'(ref_pick(2'b01));
    ref_write(16'h0080, 32'hC0FFEE11, 4'hF);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1; m_axi_awready = 1'b1;
    n = 0;
    while (rsp_own_q.size() == r0 && n < 100) begin wait_neg(); n++; end
    wait_neg(); wait_neg();
    checks++; if (awv_cycles - awv0 !== 5) begin errors++; $display("FAIL aw_stall awvalid cycles got=%0d exp=5", awv_cycles - awv0); end
    checks++; if ({aw_hs - aw0, w_hs - w0, wv_cycles - wv0, b_hs - b0} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
      errors++; $display("FAIL aw_stall aw=%0d w=%0d wv_cycles=%0d b=%0d exp 1/1/1/1", aw_hs - aw0, w_hs - w0, wv_cycles - wv0, b_hs - b0); end
    checks++; if (rsp_own_q.size() - r0 !== 1) begin errors++; $display("FAIL aw_stall rsp count got=%0d exp=1", rsp_own_q.size() - r0); end
    else begin
      checks++; if (rsp_own_q[r0] !== 2'b01) begin errors++; $display("FAIL aw_stall rsp_valid got=%b exp=01", rsp_own_q[r0]); end
    end
    run_txn(1, 1'b0, 16'h0080, 32'h0, 4'h0, 1'b1, "aw_stall_readback", got);
  endtask

  task automatic test_strobe();
    logic [31:0] got;
    run_txn(0, 1'b1, 16'h0020, 32'hAABBCCDD, 4'hF, 1'b1, "strb_full", got);
    run_txn(1, 1'b1, 16'h0020, 32'h11223344, 4'b0101, 1'b1, "strb_part", got);
    run_txn(0, 1'b0, 16'h0020, 32'h0, 4'h0, 1'b1, "strb_read", got);
    checks++; if (got !== 32'hAA22CC44) begin errors++; $display("FAIL strb_read value got=%h exp=aa22cc44", got); end
  endtask

  task automatic test_random();
    logic [31:0] got;
    for (int i = 0; i < 30; i++) begin
      slave_resp = 2'($urandom_range(0, 3));
      run_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              16'h0100 + 16'($urandom_range(0, 7) * 4), $urandom, 4'($urandom_range(0, 15)),
              1'b1, "random", got);
    end
    slave_resp = 2'b00;
  endtask

  task automatic test_reset_mid();
    int g0, r0, n;
    b_hold = 1'b1;
    @(posedge clk); #1;
    g0 = grant_q.size();
    set_port(0, 1'b1, 16'h0090, 32'h12345678, 4'hF);
    req_valid[0] = 1'b1;
    n = 0;
    while (grant_q.size() == g0 && n < 50) begin wait_neg(); n++; end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (!m_axi_bready && n < 50) begin wait_neg(); n++; end
    checks++; if (m_axi_bready !== 1'b1) begin errors++; $display("FAIL reset_mid bready got=%b exp=1", m_axi_bready); end
    r0 = rsp_own_q.size();
    @(posedge clk); #1;
    RESET = 1'b1;
    @(posedge clk); #1;
    RESET = 1'b0; b_hold = 1'b0;
    ref_last = 1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    wait_neg();
    checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid} !== 7'b0) begin
      errors++; $display("FAIL reset_mid valids got=%b exp=0000000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid}); end
    repeat (4) wait_neg();
    checks++; if (rsp_own_q.size() - r0 !== 0) begin errors++; $display("FAIL reset_mid stray rsp count got=%0d exp=0", rsp_own_q.size() - r0); end
    set_port(0, 1'b0, 16'h0090, 32'h0, 4'h0);
    set_port(1, 1'b0, 16'h0094, 32'h0, 4'h0);
    run_held(2'b11, 2, "after_reset");
  endtask

  initial begin
    RESET = 1'b1;
    req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
    b_hold = 1'b0; slave_resp = 2'b00;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_write_read();
    test_alternation();
    test_back_to_back();
    test_aw_stall();
    test_strobe();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule
